// File: rtl/clkgate_ctrl.sv
// Purpose: per-domain clock-gate enable controller (idle-timeout gating, settled wake with ack).
// Latency: gates after T+1 idle edges; clk_en rises 1 edge after wake; RUN after WAKE_CYCLES more edges.
// Backpressure: none; wake_req is a level held by the requester until wake_ack is returned.
//
// Ports:
//   clk              root (ungated) clock, runs during reset
//   rst_n            async active-low reset, released internally on clk
//   cfg_idle_timeout shared idle timeout T (quasi-static, sampled only at counter load)
//   cfg_force_on     per-domain override keeping the clock running
//   busy             per-domain activity, ignored while GATED
//   wake_req         per-domain level wake request
//   wake_ack         registered: domain running and request still asserted
//   clk_en           registered enable to each domain's clock-gate cell
//   status_gated     registered: domain currently in GATED
module clkgate_ctrl #(
  parameter int N_DOMAINS   = 4,
  parameter int W_IDLE      = 8,
  parameter int WAKE_CYCLES = 2   // legal range 1..15 (fits the 4-bit wake counter)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W_IDLE-1:0]    cfg_idle_timeout,
  input  logic [N_DOMAINS-1:0] cfg_force_on,
  input  logic [N_DOMAINS-1:0] busy,
  input  logic [N_DOMAINS-1:0] wake_req,
  output logic [N_DOMAINS-1:0] wake_ack,
  output logic [N_DOMAINS-1:0] clk_en,
  output logic [N_DOMAINS-1:0] status_gated
);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_IDLE_WAIT = 2'd1,
    S_GATED     = 2'd2,
    S_WAKE      = 2'd3
  } state_t;

  localparam logic [3:0]        WAKE_LOAD = 4'(WAKE_CYCLES - 1);
  localparam logic [W_IDLE-1:0] IDLE_ONE  = W_IDLE'(1);
  localparam logic [W_IDLE-1:0] IDLE_ZERO = '0;

  // Reset synchronizer: assertion is asynchronous (forces every clk_en high
  // at once), release is aligned to clk so all domain FSMs leave reset on
  // the same edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  for (genvar d = 0; d < N_DOMAINS; d++) begin : g_dom
    state_t            state;
    logic [W_IDLE-1:0] idle_cnt;
    logic [3:0]        wake_cnt;
    logic              gated;
    logic              ack;
    logic              idle;
    logic              wake;

    assign idle = !busy[d] && !wake_req[d] && !cfg_force_on[d];
    assign wake = wake_req[d] || cfg_force_on[d];

    // One process per domain. 'gated' is written alongside every transition
    // into or out of GATED so it always equals (state == S_GATED) but comes
    // straight from a flop: the gate-cell enable never sees decode glitches.
    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        state    <= S_RUN;
        idle_cnt <= '0;
        wake_cnt <= '0;
        gated    <= 1'b0;
        ack      <= 1'b0;
      end else begin
        // Ack uses the pre-edge state: it rises the edge after RUN is reached
        // and falls the edge after the request drops.
        ack <= wake_req[d] && ((state == S_RUN) || (state == S_IDLE_WAIT));

        case (state)
          S_RUN: begin
            if (idle) begin
              if (cfg_idle_timeout == IDLE_ZERO) begin
                state <= S_GATED;
                gated <= 1'b1;
              end else begin
                // Timeout is captured here only; later changes wait for the
                // next load.
                state    <= S_IDLE_WAIT;
                idle_cnt <= cfg_idle_timeout;
              end
            end
          end

          S_IDLE_WAIT: begin
            // Any activity or request wins over an expiring count.
            if (!idle) begin
              state <= S_RUN;
            end else if (idle_cnt == IDLE_ONE) begin
              state <= S_GATED;
              gated <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt - IDLE_ONE;
            end
          end

          S_GATED: begin
            if (wake) begin
              state    <= S_WAKE;
              gated    <= 1'b0;
              wake_cnt <= WAKE_LOAD;
            end
          end

          S_WAKE: begin
            // Settle period runs to completion even if the request drops.
            if (wake_cnt == 4'd0) begin
              state <= S_RUN;
            end else begin
              wake_cnt <= wake_cnt - 4'd1;
            end
          end

          default: begin
            state <= S_RUN;
            gated <= 1'b0;
          end
        endcase
      end
    end

    assign clk_en[d]       = !gated;
    assign status_gated[d] = gated;
    assign wake_ack[d]     = ack;
  end

endmodule

// File: tb/tb_clkgate_ctrl.sv
module tb_clkgate_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int WC = 2;

  localparam int M_RUN   = 0;
  localparam int M_IW    = 1;
  localparam int M_GATED = 2;
  localparam int M_WAKE  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] cfg_idle_timeout;
  logic [N-1:0] cfg_force_on;
  logic [N-1:0] busy;
  logic [N-1:0] wake_req;
  logic [N-1:0] wake_ack;
  logic [N-1:0] clk_en;
  logic [N-1:0] status_gated;

  clkgate_ctrl #(.N_DOMAINS(N), .W_IDLE(W), .WAKE_CYCLES(WC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_idle_timeout (cfg_idle_timeout),
    .cfg_force_on     (cfg_force_on),
    .busy             (busy),
    .wake_req         (wake_req),
    .wake_ack         (wake_ack),
    .clk_en           (clk_en),
    .status_gated     (status_gated)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] en;
    logic [N-1:0] ack;
    logic [N-1:0] gated;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Behavioural reference model
  int           m_state[N];
  int           m_icnt[N];
  int           m_wcnt[N];
  logic [N-1:0] m_ack;
  int           m_sync;

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_state[d] = M_RUN;
      m_icnt[d]  = 0;
      m_wcnt[d]  = 0;
    end
    m_ack  = '0;
    m_sync = 0;
  endtask

  // Evaluated at a rising edge with the inputs held from before the edge.
  task automatic model_edge();
    bit idle;
    bit wk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_sync < 2) begin
      m_sync++;
      return;
    end
    for (int d = 0; d < N; d++) begin
      idle     = !busy[d] && !wake_req[d] && !cfg_force_on[d];
      wk       = wake_req[d] || cfg_force_on[d];
      m_ack[d] = wake_req[d] && (m_state[d] == M_RUN || m_state[d] == M_IW);
      case (m_state[d])
        M_RUN: if (idle) begin
          if (cfg_idle_timeout == 0) m_state[d] = M_GATED;
          else begin
            m_state[d] = M_IW;
            m_icnt[d]  = int'(cfg_idle_timeout);
          end
        end
        M_IW: begin
          if (!idle) m_state[d] = M_RUN;
          else if (m_icnt[d] == 1) m_state[d] = M_GATED;
          else m_icnt[d] = m_icnt[d] - 1;
        end
        M_GATED: if (wk) begin
          m_state[d] = M_WAKE;
          m_wcnt[d]  = WC - 1;
        end
        default: begin
          if (m_wcnt[d] == 0) m_state[d] = M_RUN;
          else m_wcnt[d] = m_wcnt[d] - 1;
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int d = 0; d < N; d++) begin
      e.en[d]    = (m_state[d] != M_GATED);
      e.gated[d] = (m_state[d] == M_GATED);
    end
    e.ack = m_ack;
    return e;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // One clock edge: model advances, expectation queued, outputs settle.
  task automatic step();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_out());
    #1;
  endtask

  // clk_en toggle counting per cycle window
  int           tog[N];
  logic [N-1:0] en_prev;

  always @(clk_en) begin
    for (int d = 0; d < N; d++)
      if (clk_en[d] !== en_prev[d]) tog[d]++;
    en_prev = clk_en;
  end

  // Monitor: compares every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_clk_en", clk_en, mon_e.en);
      check("sb_wake_ack", wake_ack, mon_e.ack);
      check("sb_status_gated", status_gated, mon_e.gated);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (tog[d] > 1) begin
          errors++;
          $display("FAIL clk_en_toggle[%0d]: got %0d toggles in one cycle, required at most 1", d, tog[d]);
        end
      end
    end
    for (int d = 0; d < N; d++) tog[d] = 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < N; d++) tog[d] = 0;
    rst_n            = 1'b0;
    cfg_idle_timeout = 8'd3;
    busy             = 4'b1110;
    wake_req         = 4'b0000;
    cfg_force_on     = 4'b0000;
    model_reset();

    // Reset state
    step(); step();
    check("reset_clk_en", clk_en, 4'b1111);
    check("reset_wake_ack", wake_ack, 4'b0000);
    check("reset_status_gated", status_gated, 4'b0000);
    rst_n = 1'b1;
    step(); step();   // internal reset release

    // Idle gating with T=3: gated after the 4th idle edge
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("gate_t3_e%0d_en", i), clk_en, (i < 4) ? 4'b1111 : 4'b1110);
      check($sformatf("gate_t3_e%0d_gated", i), status_gated, (i < 4) ? 4'b0000 : 4'b0001);
    end

    // Wake from GATED, WAKE_CYCLES=2
    wake_req = 4'b0001;
    step(); check("wake_k_en", clk_en, 4'b1111); check("wake_k_ack", wake_ack, 4'b0000);
    step(); check("wake_k1_ack", wake_ack, 4'b0000);
    step(); check("wake_k2_ack", wake_ack, 4'b0000);
    step(); check("wake_k3_ack", wake_ack, 4'b0001);
    wake_req = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) check("wake_drop_ack", wake_ack, 4'b0000);
      check($sformatf("regate_e%0d_en", i), clk_en, (i < 4) ? 4'b1111 : 4'b1110);
    end

    // Busy pulse restarts the idle count
    wake_req = 4'b0001;
    step(); step(); step(); step();
    check("rewake_ack", wake_ack, 4'b0001);
    wake_req = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("pre_pulse_e%0d_en", i), clk_en, 4'b1111);
    end
    busy = 4'b1111;
    step(); check("busy_pulse_en", clk_en, 4'b1111);
    busy = 4'b1110;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("post_pulse_e%0d_en", i), clk_en, (i < 4) ? 4'b1111 : 4'b1110);
    end

    // T=0: gate after one idle edge; force_on pulse wakes and regates
    cfg_idle_timeout = 8'd0;
    busy             = 4'b0110;
    step();
    check("t0_gate_en", clk_en, 4'b0110);
    check("t0_gate_gated", status_gated, 4'b1001);
    cfg_force_on = 4'b0001;
    step(); check("force_k_en", clk_en, 4'b0111);
    cfg_force_on = 4'b0000;
    step(); check("force_k1_en", clk_en, 4'b0111);
    step(); check("force_k2_en", clk_en, 4'b0111); check("force_k2_gated", status_gated, 4'b1000);
    step(); check("force_k3_en", clk_en, 4'b0110); check("force_k3_ack", wake_ack, 4'b0000);

    // Async reset with domain 2 GATED and domain 1 in WAKE (domain 0 acked)
    busy     = 4'b0000;
    wake_req = 4'b0001;
    step(); check("pre_rst_s1_en", clk_en, 4'b0001);
    step(); step();
    wake_req = 4'b0011;
    step();
    check("pre_rst_en", clk_en, 4'b0011);
    check("pre_rst_ack", wake_ack, 4'b0001);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_en", clk_en, 4'b1111);
    check("async_rst_ack", wake_ack, 4'b0000);
    check("async_rst_gated", status_gated, 4'b0000);
    busy     = 4'b1111;
    wake_req = 4'b0000;
    step();
    rst_n = 1'b1;
    step(); step(); step();
    check("post_rst_en", clk_en, 4'b1111);
    check("post_rst_gated", status_gated, 4'b0000);

    // Random traffic on all domains, checked by the scoreboard
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < N; d++) begin
        busy[d]         = ($urandom_range(0, 3) == 0);
        wake_req[d]     = ($urandom_range(0, 11) == 0);
        cfg_force_on[d] = ($urandom_range(0, 23) == 0);
      end
      if ($urandom_range(0, 49) == 0) cfg_idle_timeout = 8'($urandom_range(0, 3));
      step();
    end

    busy         = '0;
    wake_req     = '0;
    cfg_force_on = '0;
    step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
